// File: rtl/tx_byte_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tx_byte_arbiter_pkg                                    |
// | Description : Shared types and constants for the TX byte arbiter.    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package tx_byte_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t c_ST_IDLE  = 2'd0;
  localparam arb_state_t c_ST_FETCH = 2'd1;
  localparam arb_state_t c_ST_SEND  = 2'd2;

  // Descriptor length is carried at its widest; users keep the low bits.
  localparam int unsigned c_DESC_LEN_MAX_W = 32;

  typedef struct packed {
    logic [c_DESC_LEN_MAX_W-1:0] len;
  } tx_desc_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tx_rr_arb2                                             |
// | Description : Two-way round-robin grant, pointer moves on accept.    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tx_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_any,
  output logic       o_gnt
);

  // r_rr names the requester that loses the next tie.
  logic r_rr;

  always_comb begin
    o_any = |i_req;
    case (i_req)
      2'b01:   o_gnt = 1'b0;
      2'b10:   o_gnt = 1'b1;
      2'b11:   o_gnt = ~r_rr;
      default: o_gnt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= 1'b1;
    end else if (i_accept) begin
      r_rr <= o_gnt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_byte_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tx_byte_arbiter                                        |
// | Description : Arbitrates two word queues onto one LSB-first byte     |
// |               stream, one message per grant, length-truncated.       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tx_byte_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             desc_valid_i,
  output logic [1:0]             desc_ready_o,
  input  logic [2*LEN_WIDTH-1:0] desc_len_i,
  input  logic [1:0]             data_valid_i,
  output logic [1:0]             data_ready_o,
  input  logic [2*WIDTH-1:0]     data_i,
  output logic                   source_valid_o,
  input  logic                   source_ready_i,
  output logic [7:0]             source_data_o,
  output logic                   source_last_o,
  output logic                   source_id_o,
  output logic                   busy_o
);
  import tx_byte_arbiter_pkg::*;

  localparam int unsigned          c_BYTES     = WIDTH / 8;
  localparam int unsigned          c_WB_W      = $clog2(c_BYTES) + 1;
  localparam logic [LEN_WIDTH-1:0] c_BYTES_LEN = LEN_WIDTH'(c_BYTES);
  localparam logic [LEN_WIDTH-1:0] c_ONE_LEN   = LEN_WIDTH'(1);
  localparam logic [c_WB_W-1:0]    c_BYTES_WB  = c_WB_W'(c_BYTES);
  localparam logic [c_WB_W-1:0]    c_ONE_WB    = c_WB_W'(1);

  generate
    if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_bad_width
      $error("tx_byte_arbiter: WIDTH must be a non-zero multiple of 8");
    end
    if (LEN_WIDTH > c_DESC_LEN_MAX_W || LEN_WIDTH < c_WB_W) begin : g_bad_len
      $error("tx_byte_arbiter: LEN_WIDTH out of supported range");
    end
  endgenerate

  arb_state_t           r_state;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [c_WB_W-1:0]    r_wbytes;
  logic [WIDTH-1:0]     r_sreg;
  logic                 r_gnt;

  logic                 w_any;
  logic                 w_gnt;
  logic                 w_accept;
  tx_desc_t             w_desc;
  logic                 w_word_valid;
  logic [WIDTH-1:0]     w_word;
  logic [c_WB_W-1:0]    w_fill;

  assign w_accept = (r_state == c_ST_IDLE) && w_any;

  tx_rr_arb2 u_arb (
    .clk      (clk_i),
    .rst      (rst_i),
    .i_req    (desc_valid_i),
    .i_accept (w_accept),
    .o_any    (w_any),
    .o_gnt    (w_gnt)
  );

  always_comb begin
    w_desc = '0;
    w_desc.len[LEN_WIDTH-1:0] = w_gnt ? desc_len_i[2*LEN_WIDTH-1:LEN_WIDTH]
                                      : desc_len_i[LEN_WIDTH-1:0];
  end

  assign w_word_valid = r_gnt ? data_valid_i[1] : data_valid_i[0];
  assign w_word       = r_gnt ? data_i[2*WIDTH-1:WIDTH] : data_i[WIDTH-1:0];
  // A short tail word only carries the bytes the message still needs.
  assign w_fill       = (r_remaining >= c_BYTES_LEN) ? c_BYTES_WB
                                                     : r_remaining[c_WB_W-1:0];

  assign desc_ready_o   = w_accept ? onehot2(w_gnt) : 2'b00;
  assign data_ready_o   = (r_state == c_ST_FETCH) ? onehot2(r_gnt) : 2'b00;
  assign source_valid_o = (r_state == c_ST_SEND);
  assign source_data_o  = r_sreg[7:0];
  assign source_last_o  = (r_state == c_ST_SEND) && (r_remaining == c_ONE_LEN);
  assign source_id_o    = r_gnt;
  assign busy_o         = (r_state != c_ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= c_ST_IDLE;
      r_remaining <= '0;
      r_wbytes    <= '0;
      r_sreg      <= '0;
      r_gnt       <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_gnt       <= w_gnt;
            r_remaining <= w_desc.len[LEN_WIDTH-1:0];
            r_state     <= (w_desc.len != '0) ? c_ST_FETCH : c_ST_IDLE;
          end
        end
        c_ST_FETCH: begin
          if (w_word_valid) begin
            r_sreg   <= w_word;
            r_wbytes <= w_fill;
            r_state  <= c_ST_SEND;
          end
        end
        c_ST_SEND: begin
          if (source_ready_i) begin
            r_sreg      <= r_sreg >> 8;
            r_remaining <= r_remaining - c_ONE_LEN;
            r_wbytes    <= r_wbytes - c_ONE_WB;
            if (r_remaining == c_ONE_LEN) begin
              r_state <= c_ST_IDLE;
            end else if (r_wbytes == c_ONE_WB) begin
              r_state <= c_ST_FETCH;
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_byte_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_tx_byte_arbiter                                     |
// | Description : Scoreboard bench with per-requester message drivers.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_tx_byte_arbiter;

  localparam int W  = 32;
  localparam int LW = 16;
  localparam int NB = W / 8;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [1:0]      desc_valid_i;
  logic [1:0]      desc_ready_o;
  logic [2*LW-1:0] desc_len_i;
  logic [1:0]      data_valid_i;
  logic [1:0]      data_ready_o;
  logic [2*W-1:0]  data_i;
  logic            source_valid_o;
  logic            source_ready_i = 1'b1;
  logic [7:0]      source_data_o;
  logic            source_last_o;
  logic            source_id_o;
  logic            busy_o;

  always #5 clk = ~clk;

  tx_byte_arbiter #(.WIDTH(W), .LEN_WIDTH(LW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .desc_valid_i   (desc_valid_i),
    .desc_ready_o   (desc_ready_o),
    .desc_len_i     (desc_len_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
    .data_i         (data_i),
    .source_valid_o (source_valid_o),
    .source_ready_i (source_ready_i),
    .source_data_o  (source_data_o),
    .source_last_o  (source_last_o),
    .source_id_o    (source_id_o),
    .busy_o         (busy_o)
  );

  int         checks = 0;
  int         failures = 0;
  int         msg_q[2][$];
  logic [8:0] exp_q[2][$];
  bit         drv_busy[2];
  int         dhs[2];
  bit         fixed_mode = 1'b1;
  int         ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each requester turns a queued length into a descriptor plus ceil(len/NB) words.
  for (genvar r = 0; r < 2; r++) begin : g_req
    logic          dv = 1'b0;
    logic          wv = 1'b0;
    logic [LW-1:0] dl = '0;
    logic [W-1:0]  wd = '0;
    assign desc_valid_i[r]       = dv;
    assign data_valid_i[r]       = wv;
    assign desc_len_i[r*LW +: LW] = dl;
    assign data_i[r*W +: W]      = wd;

    initial begin
      int           len;
      int           nw;
      int           tmo;
      logic [7:0]   b;
      logic [W-1:0] word;
      logic [W-1:0] words[$];
      forever begin
        @(posedge clk); #1;
        if (msg_q[r].size() != 0) begin
          drv_busy[r] = 1'b1;
          len = msg_q[r].pop_front();
          nw  = (len + NB - 1) / NB;
          words.delete();
          for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int k = 0; k < NB; k++) begin
              b = fixed_mode ? 8'((w*NB + k + 1) * 17) : 8'($urandom);
              word[k*8 +: 8] = b;
              if (w*NB + k < len) exp_q[r].push_back({(w*NB + k == len - 1), b});
            end
            words.push_back(word);
          end
          dl = LW'(len);
          dv = 1'b1;
          tmo = 0;
          do begin @(negedge clk); tmo++; end while (!desc_ready_o[r] && tmo < 3000);
          chk($sformatf("desc_accept_r%0d", r), 32'(desc_ready_o[r]), 32'd1);
          @(posedge clk); #1;
          dv = 1'b0;
          for (int w = 0; w < nw; w++) begin
            wd = words[w];
            wv = 1'b1;
            tmo = 0;
            do begin @(negedge clk); tmo++; end while (!data_ready_o[r] && tmo < 3000);
            chk($sformatf("word_accept_r%0d", r), 32'(data_ready_o[r]), 32'd1);
            @(posedge clk); #1;
            wv = 1'b0;
            if (!fixed_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          end
          drv_busy[r] = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       source_ready_i = ($time / 10) % 3 == 0;
        2:       source_ready_i = 1'($urandom_range(0, 1));
        default: source_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: message-level model of arbitration and byte ownership.
  initial begin
    bit         active;
    bit         last_win;
    bit         own;
    bit         ew;
    bit         prev_stall;
    logic [9:0] prev_out;
    logic [1:0] exp_rdy;
    logic [8:0] e;
    logic [LW-1:0] wl;
    active = 0; last_win = 1; own = 0; prev_stall = 0; prev_out = '0; ew = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        active = 0; last_win = 1; own = 0; prev_stall = 0;
      end else begin
        if (prev_stall)
          chk("stall_hold", 32'({source_valid_o, source_last_o, source_id_o, source_data_o}),
              32'({1'b1, prev_out}));
        exp_rdy = 2'b00;
        if (!active && desc_valid_i != 2'b00) begin
          ew = (desc_valid_i == 2'b11) ? ~last_win : desc_valid_i[1];
          exp_rdy = ew ? 2'b10 : 2'b01;
        end
        chk("desc_ready", 32'(desc_ready_o), 32'(exp_rdy));
        chk("busy", 32'(busy_o), 32'(active));
        if (!active) chk("idle_quiet", 32'({data_ready_o, source_valid_o}), 32'd0);
        else         chk("data_ready_owner", 32'(data_ready_o & (own ? 2'b01 : 2'b10)), 32'd0);
        for (int r = 0; r < 2; r++)
          if (data_valid_i[r] && data_ready_o[r]) dhs[r]++;
        if (source_valid_o && source_ready_i && active) begin
          chk("source_id", 32'(source_id_o), 32'(own));
          if (exp_q[own].size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_byte: got byte 0x%0h id %0d, expected no byte", source_data_o, own);
          end else begin
            e = exp_q[own].pop_front();
            chk("byte", 32'({source_last_o, source_data_o}), 32'(e));
            if (e[8]) active = 0;
          end
        end
        if (exp_rdy != 2'b00) begin
          last_win = ew;
          wl = ew ? desc_len_i[2*LW-1:LW] : desc_len_i[LW-1:0];
          if (wl != '0) begin active = 1; own = ew; end
        end
        prev_stall = source_valid_o && !source_ready_i;
        prev_out   = {source_last_o, source_id_o, source_data_o};
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(msg_q[0].size() == 0 && msg_q[1].size() == 0 && !drv_busy[0] && !drv_busy[1] &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0 && !busy_o) && n < 20000);
    chk("idle_reached", 32'(n < 20000), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_desc_ready"}, 32'(desc_ready_o), 32'd0);
    chk({tag, "_data_ready"}, 32'(data_ready_o), 32'd0);
    chk({tag, "_outputs"}, 32'({source_valid_o, source_last_o, source_id_o, busy_o, source_data_o}), 32'd0);
  endtask

  initial begin
    int base[2];
    int expw[2];
    int n;
    int r;
    int len;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_i = 1'b0;

    // Single message, len 6, two words, top two bytes dropped.
    base[0] = dhs[0];
    msg_q[0].push_back(6);
    wait_idle();
    chk("words_len6", 32'(dhs[0] - base[0]), 32'd2);

    // Zero-length descriptor.
    base[1] = dhs[1];
    msg_q[1].push_back(0);
    wait_idle();
    chk("words_len0", 32'(dhs[1] - base[1]), 32'd0);

    // Contention with single-byte messages.
    repeat (4) begin
      msg_q[0].push_back(1);
      msg_q[1].push_back(1);
      wait_idle();
    end
    msg_q[0].push_back(1); msg_q[0].push_back(1); msg_q[0].push_back(1);
    msg_q[1].push_back(1); msg_q[1].push_back(1); msg_q[1].push_back(1);
    wait_idle();

    // Backpressure 1,0,0,1,...
    ready_mode = 1;
    msg_q[0].push_back(4);
    wait_idle();
    ready_mode = 0;

    // Late descriptor from requester 1 while requester 0 owns the stream.
    msg_q[0].push_back(8);
    n = 0;
    do begin @(negedge clk); n++; end while (!busy_o && n < 200);
    chk("busy_seen", 32'(busy_o), 32'd1);
    msg_q[1].push_back(2);
    wait_idle();

    // Reset while byte 2 of 4 is presented.
    msg_q[0].push_back(4);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(source_valid_o && source_data_o == 8'h22) && n < 200);
    chk("byte2_seen", 32'({source_valid_o, source_data_o}), 32'h122);
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    msg_q[0].push_back(2);
    wait_idle();

    // Random traffic with random backpressure.
    fixed_mode = 1'b0;
    ready_mode = 2;
    base[0] = dhs[0]; base[1] = dhs[1];
    expw[0] = 0; expw[1] = 0;
    repeat (40) begin
      r   = $urandom_range(0, 1);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 40) : $urandom_range(0, 13);
      msg_q[r].push_back(len);
      expw[r] += (len + NB - 1) / NB;
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    chk("rand_words_r0", 32'(dhs[0] - base[0]), 32'(expw[0]));
    chk("rand_words_r1", 32'(dhs[1] - base[1]), 32'(expw[1]));
    chk("exp_empty", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
